// File: rtl/controladora_pkg.sv
// Shared types and constants for the countdown-timer mode controller.
package controladora_pkg;

  localparam int unsigned VAL_W = 8;

  localparam logic [2:0] MODO_IDLE  = 3'd0;
  localparam logic [2:0] MODO_SET   = 3'd1;
  localparam logic [2:0] MODO_RUN   = 3'd2;
  localparam logic [2:0] MODO_PAUSE = 3'd3;
  localparam logic [2:0] MODO_DONE  = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = MODO_IDLE,
    ST_SET   = MODO_SET,
    ST_RUN   = MODO_RUN,
    ST_PAUSE = MODO_PAUSE,
    ST_DONE  = MODO_DONE
  } estado_t;

endpackage

// File: rtl/contador_regressivo.sv
// Loadable 8-bit down-counter that saturates at zero; load beats enable.
module contador_regressivo
  import controladora_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [VAL_W-1:0] load_val,
  input  logic             en,
  output logic [VAL_W-1:0] cnt_next_c,
  output logic             zero_next
);

  logic [VAL_W-1:0] cnt_q;
  logic [VAL_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - VAL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_next_c = cnt_d;
  assign zero_next  = en && (cnt_q == VAL_W'(1));

endmodule

// File: rtl/controle_temporizador.sv
// Countdown-timer sequencer: owns setpoint, alarm counter and mode FSM.
module controle_temporizador
  import controladora_pkg::*;
#(
  parameter int unsigned MAX_VAL = 99,
  parameter int unsigned ALARM_T = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_long,
  input  logic             b_short,
  input  logic             tick,
  output logic [VAL_W-1:0] valor,
  output logic [2:0]       modo,
  output logic             rodando,
  output logic             alarme
);

  localparam int unsigned ALARM_W = $clog2(ALARM_T + 1);

  estado_t            state_q, state_d;
  logic [VAL_W-1:0]   setpoint_q, setpoint_d;
  logic [ALARM_W-1:0] alarm_q, alarm_d, alarm_inc;
  logic [VAL_W-1:0]   valor_q, valor_d;
  logic [2:0]         modo_q, modo_d;
  logic               rodando_q, rodando_d;
  logic               alarme_q, alarme_d;

  logic               cnt_load, cnt_en, zero_next;
  logic [VAL_W-1:0]   cnt_load_val, cnt_next;

  contador_regressivo u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (cnt_load),
    .load_val   (cnt_load_val),
    .en         (cnt_en),
    .cnt_next_c (cnt_next),
    .zero_next  (zero_next)
  );

  assign alarm_inc = alarm_q + ALARM_W'(1);

  // Next-state logic; a_long is always tested before b_short, pulses before tick.
  always_comb begin
    state_d      = state_q;
    setpoint_d   = setpoint_q;
    alarm_d      = alarm_q;
    cnt_load     = 1'b0;
    cnt_load_val = setpoint_q;
    cnt_en       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (a_long) begin
          state_d = ST_SET;
        end else if (b_short && (setpoint_q != '0)) begin
          state_d  = ST_RUN;
          cnt_load = 1'b1;
        end
      end
      ST_SET: begin
        if (a_long) begin
          state_d = ST_IDLE;
        end else if (b_short) begin
          setpoint_d = (setpoint_q >= VAL_W'(MAX_VAL)) ? '0 : setpoint_q + VAL_W'(1);
        end
      end
      ST_RUN: begin
        if (a_long) begin
          state_d = ST_IDLE;
        end else if (b_short) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          cnt_en = 1'b1;
          if (zero_next) begin
            state_d = ST_DONE;
            alarm_d = '0;
          end
        end
      end
      ST_PAUSE: begin
        if (a_long) begin
          state_d = ST_IDLE;
        end else if (b_short) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (a_long || b_short) begin
          state_d = ST_IDLE;
          alarm_d = '0;
        end else if (tick) begin
          alarm_d = alarm_inc;
          if (alarm_inc == ALARM_W'(ALARM_T)) begin
            state_d = ST_IDLE;
            alarm_d = '0;
          end
        end
      end
      default: begin
        state_d      = ST_IDLE;
        alarm_d      = '0;
        cnt_load     = 1'b1;
        cnt_load_val = '0;
      end
    endcase
  end

  // Outputs are decoded from next-state values so they register in step with the state.
  always_comb begin
    valor_d   = '0;
    modo_d    = 3'(state_d);
    rodando_d = (state_d == ST_RUN);
    alarme_d  = (state_d == ST_DONE);
    case (state_d)
      ST_IDLE, ST_SET:  valor_d = setpoint_d;
      ST_RUN, ST_PAUSE: valor_d = cnt_next;
      default:          valor_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      setpoint_q <= '0;
      alarm_q    <= '0;
      valor_q    <= '0;
      modo_q     <= MODO_IDLE;
      rodando_q  <= 1'b0;
      alarme_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      setpoint_q <= setpoint_d;
      alarm_q    <= alarm_d;
      valor_q    <= valor_d;
      modo_q     <= modo_d;
      rodando_q  <= rodando_d;
      alarme_q   <= alarme_d;
    end
  end

  assign valor   = valor_q;
  assign modo    = modo_q;
  assign rodando = rodando_q;
  assign alarme  = alarme_q;

endmodule
